// File: rtl/plab3_mem_line_memory.sv
//============================================================================
// Module   : plab3_mem_line_memory
// Purpose  : Blocking, single-outstanding-request line memory that serves
//            128-bit-line requests from the L2 cache. Each accepted request
//            gets its response after a fixed, programmable latency.
//            Writes and inits store the byte range [offset, offset+nb) of a
//            line, wrapping modulo 16. Reads return that same range,
//            zero-filled above nb.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            memreq_msg/val/rdy   - request stream
//                                   {type[3], opaque[o], addr[32], len[4], data[128]}
//            memresp_msg/val/rdy  - response stream
//                                   {type[3], opaque[o], len[4], data[128]}
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module plab3_mem_line_memory #(
  parameter  int p_mem_nbytes   = 4096,
  parameter  int p_opaque_nbits = 8,
  parameter  int p_latency      = 2,
  localparam int abw            = 32,
  localparam int clw            = 128,
  localparam int req_nbits      = 3 + p_opaque_nbits + abw + 4 + clw,
  localparam int resp_nbits     = 3 + p_opaque_nbits + 4 + clw
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [req_nbits-1:0]  memreq_msg,
  input  logic                  memreq_val,
  output logic                  memreq_rdy,
  output logic [resp_nbits-1:0] memresp_msg,
  output logic                  memresp_val,
  input  logic                  memresp_rdy
);

  localparam int nlines    = p_mem_nbytes / 16;
  localparam int addr_bits = $clog2(p_mem_nbytes);
  localparam int idx_w     = (addr_bits > 4) ? addr_bits - 4 : 1;
  localparam logic [3:0] lat_init = 4'(p_latency);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Request field extraction
  logic [2:0]                req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [abw-1:0]            req_addr;
  logic [3:0]                req_len;
  logic [clw-1:0]            req_data;

  assign req_data   = memreq_msg[clw-1:0];
  assign req_len    = memreq_msg[clw +: 4];
  assign req_addr   = memreq_msg[clw+4 +: abw];
  assign req_opaque = memreq_msg[clw+4+abw +: p_opaque_nbits];
  assign req_type   = memreq_msg[req_nbits-1 -: 3];

  logic [idx_w-1:0] line_idx;
  logic [3:0]       byte_off;

  assign byte_off = req_addr[3:0];

  // Upper address bits are deliberately dropped so that out-of-range
  // addresses alias onto the array.
  generate
    if (nlines > 1) begin : g_idx_multi
      logic unused_addr_hi;
      assign line_idx       = req_addr[4 +: idx_w];
      assign unused_addr_hi = ^req_addr[abw-1:4+idx_w];
    end else begin : g_idx_single
      logic unused_addr_hi;
      assign line_idx       = '0;
      assign unused_addr_hi = ^req_addr[abw-1:4];
    end
  endgenerate

  logic [clw-1:0] mem [nlines];

  logic [1:0]            state;
  logic [3:0]            count;
  logic [resp_nbits-1:0] resp_reg;

  logic           accept;
  logic           is_write;
  logic [4:0]     nbytes;
  logic [clw-1:0] cur_line;
  logic [clw-1:0] wr_line;
  logic [clw-1:0] rd_data;

  assign accept   = (state == ST_IDLE) && memreq_val;
  assign is_write = (req_type == 3'd1) || (req_type == 3'd2);
  assign nbytes   = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
  assign cur_line = mem[line_idx];

  // Request byte k maps to line byte (offset + k) mod 16; the 4-bit add
  // supplies the wrap for free.
  always_comb begin
    logic [3:0] pos;
    logic [6:0] lbit;
    logic [6:0] kbit;
    wr_line = cur_line;
    rd_data = '0;
    pos     = '0;
    lbit    = '0;
    kbit    = '0;
    for (int k = 0; k < 16; k++) begin
      pos  = byte_off + 4'(k);
      lbit = {pos, 3'b000};
      kbit = {4'(k), 3'b000};
      if (5'(k) < nbytes) begin
        wr_line[lbit +: 8] = req_data[kbit +: 8];
        rd_data[kbit +: 8] = cur_line[lbit +: 8];
      end
    end
  end

  // The array is not cleared by reset; a write whose accept edge coincides
  // with reset is not a real accept and must not land.
  always_ff @(posedge clk) begin
    if (!reset && accept && is_write) begin
      mem[line_idx] <= wr_line;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= 4'd0;
      resp_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (memreq_val) begin
            resp_reg <= {req_type, req_opaque, req_len,
                         is_write ? {clw{1'b0}} : rd_data};
            count    <= lat_init;
            state    <= (lat_init != 4'd0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (memresp_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs come straight from state: no input-to-output path.
  assign memreq_rdy  = (state == ST_IDLE);
  assign memresp_val = (state == ST_RESP);
  assign memresp_msg = resp_reg;

endmodule

`default_nettype wire

// File: tb/tb_plab3_mem_line_memory.sv
//============================================================================
// Module   : tb_plab3_mem_line_memory
// Purpose  : Directed bench for plab3_mem_line_memory. Three instances with
//            latency 2, 0 and 5 share clock and reset.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_plab3_mem_line_memory;

  localparam int REQ_W  = 175;
  localparam int RESP_W = 143;

  logic              clk;
  logic              reset;
  logic [REQ_W-1:0]  req_msg  [3];
  logic              req_val  [3];
  logic              req_rdy  [3];
  logic [RESP_W-1:0] resp_msg [3];
  logic              resp_val [3];
  logic              resp_rdy [3];

  int vectors;
  int fails;

  plab3_mem_line_memory #(.p_mem_nbytes(4096), .p_opaque_nbits(8), .p_latency(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .memreq_msg(req_msg[0]), .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]),
    .memresp_msg(resp_msg[0]), .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0])
  );

  plab3_mem_line_memory #(.p_mem_nbytes(4096), .p_opaque_nbits(8), .p_latency(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .memreq_msg(req_msg[1]), .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]),
    .memresp_msg(resp_msg[1]), .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1])
  );

  plab3_mem_line_memory #(.p_mem_nbytes(4096), .p_opaque_nbits(8), .p_latency(5)) dut_l5 (
    .clk(clk), .reset(reset),
    .memreq_msg(req_msg[2]), .memreq_val(req_val[2]), .memreq_rdy(req_rdy[2]),
    .memresp_msg(resp_msg[2]), .memresp_val(resp_val[2]), .memresp_rdy(resp_rdy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                              input logic [31:0] a, input logic [3:0] l,
                                              input logic [127:0] d);
    return {t, o, a, l, d};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                                input logic [3:0] l, input logic [127:0] d);
    return {t, o, l, d};
  endfunction

  task automatic chk(input string tag, input logic [REQ_W-1:0] obs, input logic [REQ_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic [REQ_W-1:0] msg);
    int n;
    @(negedge clk);
    req_msg[d] = msg;
    req_val[d] = 1'b1;
    n = 0;
    while (req_rdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy_at_send", REQ_W'(req_rdy[d]), REQ_W'(1));
    @(posedge clk);
    #1;
    req_val[d] = 1'b0;
  endtask

  // Called #1 after the accept edge; cnt = extra edges until memresp_val.
  task automatic wait_resp(input int d, output logic [RESP_W-1:0] r, output int cnt);
    cnt = 0;
    while (resp_val[d] !== 1'b1 && cnt < 50) begin
      chk("rdy_while_busy", REQ_W'(req_rdy[d]), REQ_W'(0));
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("resp_val_seen", REQ_W'(resp_val[d]), REQ_W'(1));
    chk("rdy_low_with_val", REQ_W'(req_rdy[d]), REQ_W'(0));
    r = resp_msg[d];
  endtask

  task automatic take_resp(input int d);
    resp_rdy[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy[d] = 1'b0;
    chk("val_after_take", REQ_W'(resp_val[d]), REQ_W'(0));
    chk("rdy_after_take", REQ_W'(req_rdy[d]), REQ_W'(1));
  endtask

  task automatic transact(input int d, input string tag, input logic [REQ_W-1:0] msg,
                          input logic [RESP_W-1:0] exp, input int exp_lat);
    logic [RESP_W-1:0] r;
    int cnt;
    send(d, msg);
    wait_resp(d, r, cnt);
    chk({tag, "_lat"}, REQ_W'(cnt), REQ_W'(exp_lat));
    chk({tag, "_msg"}, REQ_W'(r), REQ_W'(exp));
    take_resp(d);
  endtask

  localparam logic [127:0] LINE40 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE80 = 128'h3456FFFF_FFFFFFFF_FFFFFFFF_FFFFFF12;
  localparam logic [127:0] ALIAS  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  initial begin
    logic [RESP_W-1:0] r;
    int cnt;
    vectors = 0;
    fails   = 0;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_msg[i]  = '0;
      req_val[i]  = 1'b0;
      resp_rdy[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_rdy", REQ_W'(req_rdy[0]), REQ_W'(1));
    chk("rst_resp_val", REQ_W'(resp_val[0]), REQ_W'(0));
    chk("rst_resp_msg", REQ_W'(resp_msg[0]), REQ_W'(0));
    chk("rst_l0_rdy", REQ_W'(req_rdy[1]), REQ_W'(1));
    chk("rst_l5_val", REQ_W'(resp_val[2]), REQ_W'(0));
    reset = 1'b0;

    // Write then read, latency 2
    transact(0, "wr40", mk_req(3'd1, 8'h11, 32'h40, 4'd0, LINE40),
             mk_resp(3'd1, 8'h11, 4'd0, 128'h0), 2);
    transact(0, "rd40", mk_req(3'd0, 8'h22, 32'h40, 4'd0, 128'h0),
             mk_resp(3'd0, 8'h22, 4'd0, LINE40), 2);

    // Partial write wrapping from byte 14 to byte 0
    transact(0, "init80", mk_req(3'd2, 8'h01, 32'h80, 4'd0, {128{1'b1}}),
             mk_resp(3'd2, 8'h01, 4'd0, 128'h0), 2);
    transact(0, "wr8e", mk_req(3'd1, 8'h02, 32'h8E, 4'd3, 128'h123456),
             mk_resp(3'd1, 8'h02, 4'd3, 128'h0), 2);
    transact(0, "rd80", mk_req(3'd0, 8'h03, 32'h80, 4'd0, 128'h0),
             mk_resp(3'd0, 8'h03, 4'd0, LINE80), 2);
    transact(0, "rd8e", mk_req(3'd0, 8'h04, 32'h8E, 4'd3, 128'h0),
             mk_resp(3'd0, 8'h04, 4'd3, 128'h123456), 2);
    // Unknown type 7 behaves as a read and echoes its type
    transact(0, "rd_t7", mk_req(3'd7, 8'h05, 32'h84, 4'd2, 128'hAAAA),
             mk_resp(3'd7, 8'h05, 4'd2, 128'hFFFF), 2);

    // Latency sweep: 0 and 5
    transact(1, "l0_wr", mk_req(3'd1, 8'h01, 32'h20, 4'd4, 128'hCAFEF00D),
             mk_resp(3'd1, 8'h01, 4'd4, 128'h0), 0);
    transact(1, "l0_rd", mk_req(3'd0, 8'hA5, 32'h20, 4'd4, 128'h0),
             mk_resp(3'd0, 8'hA5, 4'd4, 128'hCAFEF00D), 0);
    transact(2, "l5_wr", mk_req(3'd1, 8'h01, 32'h20, 4'd4, 128'hCAFEF00D),
             mk_resp(3'd1, 8'h01, 4'd4, 128'h0), 5);
    transact(2, "l5_rd", mk_req(3'd0, 8'hA5, 32'h20, 4'd4, 128'h0),
             mk_resp(3'd0, 8'hA5, 4'd4, 128'hCAFEF00D), 5);

    // Backpressure: hold memresp_rdy low 7 cycles with a second request waiting
    send(0, mk_req(3'd0, 8'h44, 32'h40, 4'd0, 128'h0));
    wait_resp(0, r, cnt);
    chk("bp_lat", REQ_W'(cnt), REQ_W'(2));
    chk("bp_msg", REQ_W'(r), REQ_W'(mk_resp(3'd0, 8'h44, 4'd0, LINE40)));
    @(negedge clk);
    req_msg[0] = mk_req(3'd0, 8'h33, 32'h80, 4'd0, 128'h0);
    req_val[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_val", REQ_W'(resp_val[0]), REQ_W'(1));
      chk("bp_hold_msg", REQ_W'(resp_msg[0]), REQ_W'(mk_resp(3'd0, 8'h44, 4'd0, LINE40)));
      chk("bp_hold_rdy", REQ_W'(req_rdy[0]), REQ_W'(0));
    end
    resp_rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy[0] = 1'b0;
    chk("bp_released_val", REQ_W'(resp_val[0]), REQ_W'(0));
    chk("bp_released_rdy", REQ_W'(req_rdy[0]), REQ_W'(1));
    @(posedge clk);
    #1;
    req_val[0] = 1'b0;
    wait_resp(0, r, cnt);
    chk("bp2_lat", REQ_W'(cnt), REQ_W'(2));
    chk("bp2_msg", REQ_W'(r), REQ_W'(mk_resp(3'd0, 8'h33, 4'd0, LINE80)));
    take_resp(0);

    // Reset while waiting: response dropped, write persists
    send(0, mk_req(3'd1, 8'h55, 32'h100, 4'd4, 128'hDEADBEEF));
    chk("mid_wait_rdy", REQ_W'(req_rdy[0]), REQ_W'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_val", REQ_W'(resp_val[0]), REQ_W'(0));
    chk("mid_rst_rdy", REQ_W'(req_rdy[0]), REQ_W'(1));
    chk("mid_rst_msg", REQ_W'(resp_msg[0]), REQ_W'(0));
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_resp", REQ_W'(resp_val[0]), REQ_W'(0));

    // Reset coinciding with a valid request: request not accepted
    @(negedge clk);
    req_msg[0] = mk_req(3'd1, 8'h66, 32'h100, 4'd4, 128'h11111111);
    req_val[0] = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    req_val[0] = 1'b0;
    chk("rst_val_rdy", REQ_W'(req_rdy[0]), REQ_W'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("rst_val_no_resp", REQ_W'(resp_val[0]), REQ_W'(0));
    transact(0, "rd100", mk_req(3'd0, 8'h77, 32'h100, 4'd4, 128'h0),
             mk_resp(3'd0, 8'h77, 4'd4, 128'hDEADBEEF), 2);

    // Aliasing: 0x1010 and 0x0010 hit the same line
    transact(0, "wr1010", mk_req(3'd1, 8'h88, 32'h1010, 4'd0, ALIAS),
             mk_resp(3'd1, 8'h88, 4'd0, 128'h0), 2);
    transact(0, "rd0010", mk_req(3'd0, 8'h99, 32'h0010, 4'd0, 128'h0),
             mk_resp(3'd0, 8'h99, 4'd0, ALIAS), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
